// File: rtl/prng_scheduler_pkg.sv
// prng_scheduler_pkg: shared FSM state encoding and the LFSR step function
//   state_t   : IDLE, LOAD, GEN, DELIVER
//   lfsr_step : one Fibonacci shift, s_next = {s[w-2:0], ^(s & mask)}, evaluated at width w
package prng_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, GEN, DELIVER} state_t;
  localparam int MAX_W = 64;
  // Callers zero-extend their state and mask to MAX_W and truncate the result back to w bits.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] mask, input int w);
    logic [MAX_W-1:0] keep;
    keep = (MAX_W'(1) << w) - MAX_W'(1);
    return ((s << 1) | MAX_W'(^(s & mask & keep))) & keep;
  endfunction
endpackage

// File: rtl/prng_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first asserted request at or above the pointer, wrapping upward
//   i_req    : request vector
//   i_ptr    : index where the search starts
//   o_onehot : one-hot winner (zero when no request)
//   o_idx    : winner index
//   o_any    : at least one request asserted
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_onehot,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int IW = $clog2(NUM_REQ);
  // Scan offsets from farthest to nearest so the nearest asserted request is written last and wins.
  always_comb begin
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) o_idx = IW'((int'(i_ptr) + k) % NUM_REQ);
  end
  assign o_any    = |i_req;
  assign o_onehot = o_any ? (NUM_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/prng_scheduler.sv
// prng_scheduler: shares one Fibonacci LFSR among NUM_REQ requesters, one fresh word per grant
//   clk, reset           : clock, asynchronous active-high reset
//   enable               : permits new arbitration in IDLE
//   seed_load, seed_in   : load a new seed (zero seed falls back to SEED)
//   req                  : level requests
//   gnt, rnd_valid       : one-cycle grant pulse and coincident valid
//   rnd_data             : delivered word, held until the next delivery
//   busy                 : FSM is not in IDLE
module prng_scheduler
  import prng_scheduler_pkg::*;
#(
  parameter int               NUM_REQ  = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAP_MASK = 8'hAA,
  parameter logic [WIDTH-1:0] SEED     = 8'hFF,
  parameter int               STEPS    = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rnd_data,
  output logic               rnd_valid,
  output logic               busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STEPS + 1);
  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_lfsr, r_seed, r_data, w_step;
  logic [IW-1:0]        r_ptr, r_win, w_idx;
  logic [NUM_REQ-1:0]   r_win_oh, r_gnt, w_onehot;
  logic                 r_valid, w_any;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );
  assign w_step    = WIDTH'(lfsr_step(MAX_W'(r_lfsr), MAX_W'(TAP_MASK), WIDTH));
  assign busy      = r_state != IDLE;
  assign gnt       = r_gnt;
  assign rnd_valid = r_valid;
  assign rnd_data  = r_data;
  // Seed load outranks arbitration; GEN runs until the counter has counted down to zero.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = seed_load ? LOAD : (enable && w_any) ? GEN : IDLE;
      LOAD:    w_next = IDLE;
      GEN:     w_next = (r_cnt == '0) ? DELIVER : GEN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_lfsr   <= SEED;
      r_seed   <= '0;
      r_data   <= '0;
      r_ptr    <= '0;
      r_win    <= '0;
      r_win_oh <= '0;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (seed_load) r_seed <= seed_in;
          else if (enable && w_any) begin
            r_win    <= w_idx;
            r_win_oh <= w_onehot;
            r_cnt    <= CW'(STEPS - 1);
          end
        end
        LOAD: r_lfsr <= (r_seed == '0) ? SEED : r_seed;
        GEN: begin
          r_lfsr <= w_step;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_data  <= w_step;
            r_gnt   <= r_win_oh;
            r_valid <= 1'b1;
          end
        end
        default: r_ptr <= (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_prng_scheduler.sv
// tb_prng_scheduler: randomized self-checking bench against a behavioural word/round-robin model
module tb_prng_scheduler;
  logic       clk = 1'b0;
  logic       reset, enable, seed_load;
  logic [7:0] seed_in, rnd_data;
  logic [3:0] req, gnt;
  logic       rnd_valid, busy;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] m_lfsr;
  int         m_ptr;
  always #5 clk = ~clk;
  prng_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .busy(busy)
  );
  function automatic logic [7:0] m_word(input logic [7:0] s);
    for (int i = 0; i < 8; i++) s = {s[6:0], 1'($countones(s & 8'hAA) % 2)};
    return s;
  endfunction
  function automatic int m_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1; enable = 0; seed_load = 0; seed_in = 0; req = 0;
    tick; tick;
    reset = 0;
    m_lfsr = 8'hFF; m_ptr = 0;
  endtask
  task automatic wait_grant(output logic [3:0] g, output logic [7:0] d, output int cyc, output logic b);
    tick;
    b = busy; cyc = 0;
    while (!rnd_valid && cyc < 40) begin tick; cyc++; end
    g = gnt; d = rnd_data;
  endtask
  task automatic run_word(input logic [3:0] r, output logic [3:0] g, eg, output logic [7:0] d, ed,
                          output int cyc, output logic b, post);
    int w;
    req = r; enable = 1;
    w = m_pick(r, m_ptr);
    eg = 4'(1 << w);
    m_lfsr = m_word(m_lfsr); ed = m_lfsr;
    m_ptr = (w + 1) % 4;
    wait_grant(g, d, cyc, b);
    tick;
    post = |gnt | rnd_valid | busy;
    req = 0;
  endtask
  task automatic load_seed(input logic [7:0] s, output logic b1, b2);
    seed_load = 1; seed_in = s;
    tick;
    b1 = busy;
    seed_load = 0; seed_in = 8'($urandom);
    tick;
    b2 = busy;
    m_lfsr = (s == 0) ? 8'hFF : s;
  endtask
  task automatic test_reset;
    do_reset;
    n_cmp++;
    if ({gnt, rnd_valid, rnd_data, busy} !== 14'd0) begin
      n_bad++; $display("FAIL reset_outputs got gnt=%b valid=%b data=%h busy=%b want all 0", gnt, rnd_valid, rnd_data, busy);
    end
  endtask
  task automatic test_default;
    logic [3:0] g, eg; logic [7:0] d, ed; int cyc; logic b, post;
    run_word(4'b0001, g, eg, d, ed, cyc, b, post);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL default_gnt got %b want 0001", g); end
    n_cmp++; if (d !== 8'h3F || ed !== 8'h3F) begin n_bad++; $display("FAIL default_data got %h want 3f", d); end
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL default_latency got %0d want 8", cyc); end
    n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL default_busy got %b want 1", b); end
    n_cmp++; if (post !== 1'b0) begin n_bad++; $display("FAIL default_pulse got %b want 0 after deliver", post); end
  endtask
  task automatic test_seed;
    logic [3:0] g, eg; logic [7:0] d, ed, s; int cyc; logic b, post, b1, b2;
    for (int i = 0; i < 6; i++) begin
      s = (i == 0) ? 8'h01 : (i == 1) ? 8'h00 : 8'($urandom);
      load_seed(s, b1, b2);
      n_cmp++; if (b1 !== 1'b1 || b2 !== 1'b0) begin n_bad++; $display("FAIL seed_busy got %b%b want 10", b1, b2); end
      run_word(4'($urandom_range(1, 15)), g, eg, d, ed, cyc, b, post);
      n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL seed_word seed=%h got %h want %h", s, d, ed); end
      n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL seed_gnt got %b want %b", g, eg); end
    end
  endtask
  task automatic test_priority;
    logic [3:0] g, eg; logic [7:0] d, ed, s; int cyc; logic b, post;
    s = 8'($urandom_range(1, 255));
    seed_load = 1; seed_in = s; req = 4'b1111; enable = 1;
    tick;
    n_cmp++; if (busy !== 1'b1 || rnd_valid !== 1'b0) begin n_bad++; $display("FAIL prio_load got busy=%b valid=%b want 1 0", busy, rnd_valid); end
    seed_load = 0; req = 0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL prio_idle got busy=%b want 0", busy); end
    m_lfsr = s;
    run_word(4'b1111, g, eg, d, ed, cyc, b, post);
    n_cmp++; if (d !== ed || g !== eg) begin n_bad++; $display("FAIL prio_word got %b/%h want %b/%h", g, d, eg, ed); end
  endtask
  task automatic test_round_robin;
    logic [3:0] g, eg, r; logic [7:0] d, ed; int cyc; logic b, post;
    int exp_idx[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    do_reset;
    for (int i = 0; i < 8; i++) begin
      r = (i < 5) ? 4'b1111 : 4'b1010;
      run_word(r, g, eg, d, ed, cyc, b, post);
      n_cmp++; if (g !== 4'(1 << exp_idx[i]) || g !== eg) begin n_bad++; $display("FAIL rr_order[%0d] got %b want %b", i, g, 4'(1 << exp_idx[i])); end
      n_cmp++; if (d !== ed || cyc !== 8) begin n_bad++; $display("FAIL rr_word[%0d] got %h/%0d want %h/8", i, d, cyc, ed); end
    end
  endtask
  task automatic test_busy_ignore;
    logic [3:0] g, eg; logic [7:0] d, ed; int cyc, w; logic b, post;
    req = 4'b0100; enable = 1;
    w = m_pick(req, m_ptr); eg = 4'(1 << w);
    m_lfsr = m_word(m_lfsr); ed = m_lfsr; m_ptr = (w + 1) % 4;
    tick; tick; tick;
    seed_load = 1; seed_in = 8'h55; enable = 0; req = 0;
    tick; tick;
    seed_load = 0; cyc = 4;
    while (!rnd_valid && cyc < 40) begin tick; cyc++; end
    n_cmp++; if (cyc !== 8 || gnt !== eg || rnd_data !== ed) begin n_bad++; $display("FAIL busy_word got %0d/%b/%h want 8/%b/%h", cyc, gnt, rnd_data, eg, ed); end
    tick;
    run_word(4'($urandom_range(1, 15)), g, eg, d, ed, cyc, b, post);
    n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL busy_noload got %h want %h", d, ed); end
  endtask
  task automatic test_reset_mid;
    logic [3:0] g, eg; logic [7:0] d, ed; int cyc; logic b, post;
    req = 4'b0010; enable = 1;
    tick; tick; tick;
    #2 reset = 1;
    #1;
    n_cmp++; if (gnt !== 4'b0 || busy !== 1'b0 || rnd_valid !== 1'b0) begin n_bad++; $display("FAIL midreset got gnt=%b busy=%b valid=%b want 0", gnt, busy, rnd_valid); end
    req = 0;
    #1 reset = 0;
    m_lfsr = 8'hFF; m_ptr = 0;
    run_word(4'b1111, g, eg, d, ed, cyc, b, post);
    n_cmp++; if (d !== 8'h3F || g !== 4'b0001) begin n_bad++; $display("FAIL midreset_next got %b/%h want 0001/3f", g, d); end
  endtask
  task automatic test_throttle;
    enable = 0; req = 4'($urandom_range(1, 15));
    for (int i = 0; i < 30; i++) begin
      tick;
      n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0 || rnd_valid !== 1'b0) begin n_bad++; $display("FAIL throttle[%0d] got busy=%b gnt=%b", i, busy, gnt); end
    end
    req = 0;
  endtask
  task automatic test_random;
    logic [3:0] g, eg; logic [7:0] d, ed; int cyc; logic b, post;
    for (int i = 0; i < 20; i++) begin
      run_word(4'($urandom_range(1, 15)), g, eg, d, ed, cyc, b, post);
      n_cmp++; if (g !== eg || d !== ed || cyc !== 8 || post !== 1'b0) begin
        n_bad++; $display("FAIL random[%0d] got %b/%h/%0d/%b want %b/%h/8/0", i, g, d, cyc, post, eg, ed);
      end
    end
  endtask
  initial begin
    test_reset;
    test_default;
    test_seed;
    test_priority;
    test_round_robin;
    test_busy_ignore;
    test_reset_mid;
    test_throttle;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prng_scheduler.md
# prng_scheduler

Shares one internal Fibonacci LFSR among `NUM_REQ` requesters. Each grant delivers one fresh pseudo-random word. The block handles seeding (rejecting the all-zero lock-up seed), round-robin arbitration, and advancing the LFSR `STEPS` times per word. It sits between the random-number consumers (test-pattern and scrambler blocks) and the shared generator.

## Interface
- `NUM_REQ`, default 4, number of requesters (≥2).
- `WIDTH`, default 8, LFSR and data width.
- `TAP_MASK`, default 8'hAA, feedback taps (bits 7,5,3,1).
- `SEED`, default 8'hFF, reset and fallback seed (must be nonzero).
- `STEPS`, default `WIDTH`, LFSR shifts per delivered word (≥1).
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `reset`, in, 1, asynchronous, active-high; clears all state immediately.
- `enable`, in, 1, permits new arbitration.
- `seed_load`, in, 1, request to load `seed_in`.
- `seed_in`, in, `WIDTH`, seed value.
- `req`, in, `NUM_REQ`, level request per requester.
- `gnt`, out, `NUM_REQ`, one-hot grant; one-cycle pulse.
- `rnd_data`, out, `WIDTH`, delivered word; held until the next delivery.
- `rnd_valid`, out, 1, pulse coincident with `gnt`.
- `busy`, out, 1, high whenever the FSM is not in IDLE.

## Operation
- **LFSR step:** `s_next = {s[WIDTH-2:0], ^(s & TAP_MASK)}`. The step is invertible, so all-zero is reachable only by loading zero.
- **FSM states:** IDLE, LOAD, GEN, DELIVER.
- **IDLE:**
  - `seed_load` goes to LOAD. Seed load has priority over `req`.
  - Otherwise, `enable && |req` selects the winner by round-robin, latches it, sets `cnt = STEPS-1`, and goes to GEN.
  - Otherwise, stay in IDLE.
- **LOAD:** `lfsr <= (seed_in == 0) ? SEED : seed_in`, then go to IDLE. `seed_in` is sampled on the IDLE→LOAD edge (registered).
- **GEN:**
  - The LFSR steps once per cycle and `cnt` decrements.
  - When `cnt == 0`, the last step is taken and the FSM goes to DELIVER.
  - On that same edge: `rnd_data <= stepped value`, `gnt[winner] <= 1`, `rnd_valid <= 1`.
- **DELIVER:**
  - `gnt` and `rnd_valid` clear, and the FSM goes to IDLE.
  - The round-robin pointer updates to `(winner+1) mod NUM_REQ`.
- **Round-robin:** search starts at the pointer and wraps upward. The first asserted `req` wins. The pointer resets to 0.
- **Request rule:** each grant serves exactly one word. A requester that keeps `req` high competes again on its next turn. `req` dropping during GEN does not cancel the transaction.
- **Ignored inputs outside IDLE:** `seed_load` is ignored (not queued). `enable` falling mid-GEN does not abort the word.
- **Reset values:** `lfsr = SEED`, state IDLE, pointer 0, `gnt = 0`, `rnd_valid = 0`, `rnd_data = 0`, `busy = 0`.
- **Reset mid-GEN or mid-DELIVER:** the word is abandoned and no grant is issued.

## Timing
- `req` is sampled in IDLE at edge E.
- `gnt` and `rnd_valid` go high at edge E+`STEPS` and fall at E+`STEPS`+1.
- The earliest next arbitration edge is E+`STEPS`+2, giving a throughput of one word per `STEPS`+2 cycles.
- Seed load takes 2 edges: IDLE→LOAD, then LOAD→IDLE with the LFSR written.
- `busy` is combinational from state.
- `gnt`, `rnd_valid` and `rnd_data` are registered.

## Structure
- **Shared package:** state enum {IDLE, LOAD, GEN, DELIVER} and the `lfsr_step` function (width/mask-parameterised).
- **Sub-module:** `rr_arbiter`, parameterised by `NUM_REQ`. It takes `req` and the pointer and returns a one-hot winner plus an index.
- **Top:** holds the FSM, the step counter (`$clog2(STEPS+1)` bits), the LFSR register and the output registers.

## Test plan
- **Default word:** reset, `enable=1`, `req=4'b0001`. Expect `gnt=4'b0001` and `rnd_valid` high for 1 cycle, exactly 8 edges after sampling, with `rnd_data=8'h3F` (sequence FE,FC,F9,F3,E7,CF,9F,3F).
- **Seed load, STEPS=1:** `seed_load` with `seed_in=8'h01`, then one request. Expect `rnd_data=8'h02`. Then load `seed_in=8'h00` and request again. Expect the LFSR was loaded with 8'hFF, giving first word 8'hFE.
- **Round-robin fairness:** hold `req=4'b1111`. Expect grants in order 0,1,2,3,0, each spaced `STEPS`+2 cycles apart. Then `req=4'b1010` with pointer at 1 gives 1,3,1.
- **Ignored inputs while busy:** assert `seed_load` during GEN and drop `enable` during GEN. Expect the current word to complete unchanged and no LFSR load afterwards.
- **Reset mid-operation:** assert `reset` in the 3rd GEN cycle. Expect immediate `gnt=0`, `busy=0`, and LFSR=FF. The next request yields 8'h3F again.
- **Throttle:** keep `enable=0` with `req` high. Expect no grant and `busy=0` indefinitely.
